// File: rtl/imem_sync_loadable.sv
// -----------------------------------------------------------------------------
// imem_sync_loadable
//   Instruction memory for the 8-bit CPU. It has a synchronous-read fetch port
//   with a valid/ready handshake and a program-load write port. Reset restores
//   a small boot image, so a board can start without an external loader.
//
//   Optional feature macro: IMEM_PARITY_EN
//     defined   -> one even-parity bit is stored per word. A fetch whose stored
//                  parity mismatches raises parity_err alongside instr_valid.
//     undefined -> no parity storage, and parity_err is tied low.
//
// Ports
//   clk          in   1       rising-edge clock
//   reset        in   1       synchronous, active-high; overrides all inputs
//   fetch_req    in   1       fetch request from the PC stage
//   fetch_addr   in   ADDR_W  word address to fetch
//   fetch_ready  out  1       fetch accepted on an edge where fetch_req=1
//   instr_valid  out  1       one-cycle pulse per accepted fetch
//   instruction  out  DATA_W  fetched word, held until the next accepted fetch
//   addr_err     out  1       pulses with instr_valid for an out-of-range fetch
//   load_en      in   1       write load_data to load_addr on this edge
//   load_addr    in   ADDR_W  load word address
//   load_data    in   DATA_W  load word
//   load_done    out  1       sticky flag: a load has occurred since reset
//   parity_err   out  1       stored-parity mismatch on the fetched word
// -----------------------------------------------------------------------------
module imem_sync_loadable #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_ready,
   output logic              instr_valid,
   output logic [DATA_W-1:0] instruction,
   output logic              addr_err,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   output logic              load_done,
   output logic              parity_err
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // The limit is one bit wider than the address, so that
   // DEPTH == 2**ADDR_W is still representable.
   localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

   typedef enum logic {ST_IDLE, ST_LOAD} state_t;

   state_t state_reg, state_next;

   logic [DATA_W-1:0] mem_reg [DEPTH];
   logic              instr_valid_reg;
   logic [DATA_W-1:0] instruction_reg;
   logic              addr_err_reg;
   logic              load_done_reg;

   logic              fetch_accept;
   logic              fetch_in_range;
   logic              load_in_range;
   logic [IDX_W-1:0]  fetch_idx;
   logic [IDX_W-1:0]  load_idx;

   // Boot image. Each word is zero-extended to DATA_W.
   function automatic logic [DATA_W-1:0] boot_word(input int idx);
      case (idx)
         0:       return DATA_W'(8'h49);
         1:       return DATA_W'(8'hC1);
         2:       return DATA_W'(8'h18);
         3:       return DATA_W'(8'hA9);
         4:       return DATA_W'(8'h4D);
         default: return '0;
      endcase
   endfunction

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (reset) state_reg <= ST_IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next  = state_reg;
      fetch_ready = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            // Ready depends combinationally on load_en, so a load always wins
            // a same-cycle conflict. The requester keeps fetch_req asserted.
            fetch_ready = !load_en;
            if (load_en) state_next = ST_LOAD;
         end
         ST_LOAD: begin
            if (!load_en) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign fetch_accept   = fetch_req && fetch_ready;
   assign fetch_in_range = {1'b0, fetch_addr} < DEPTH_LIM;
   assign load_in_range  = {1'b0, load_addr}  < DEPTH_LIM;
   assign fetch_idx      = fetch_addr[IDX_W-1:0];
   assign load_idx       = load_addr[IDX_W-1:0];

   // ---------------------------------------------------------------- storage
   // The array is built from registers rather than block RAM, because reset
   // has to restore every word of the boot image.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem_reg[i] <= boot_word(i);
      end else if (load_en && load_in_range) begin
         mem_reg[load_idx] <= load_data;
      end
   end

   // ---------------------------------------------------------------- read side
   always_ff @(posedge clk) begin
      if (reset) begin
         instr_valid_reg <= 1'b0;
         instruction_reg <= '0;
         addr_err_reg    <= 1'b0;
         load_done_reg   <= 1'b0;
      end else begin
         instr_valid_reg <= fetch_accept;
         addr_err_reg    <= fetch_accept && !fetch_in_range;
         // An out-of-range fetch returns the NOP encoding (all zeros).
         // Addresses never wrap around.
         if (fetch_accept)
            instruction_reg <= fetch_in_range ? mem_reg[fetch_idx] : '0;
         if (load_en)
            load_done_reg <= 1'b1;
      end
   end

   assign instr_valid = instr_valid_reg;
   assign instruction = instruction_reg;
   assign addr_err    = addr_err_reg;
   assign load_done   = load_done_reg;

`ifdef IMEM_PARITY_EN
   logic [DEPTH-1:0] par_reg;
   logic             parity_err_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) par_reg[i] <= ^boot_word(i);
      end else if (load_en && load_in_range) begin
         par_reg[load_idx] <= ^load_data;
      end
   end

   // Even parity: the data bits XORed with the stored bit must give zero.
   always_ff @(posedge clk) begin
      if (reset)
         parity_err_reg <= 1'b0;
      else
         parity_err_reg <= fetch_accept && fetch_in_range &&
                           ((^mem_reg[fetch_idx]) != par_reg[fetch_idx]);
   end

   assign parity_err = parity_err_reg;
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_sync_loadable.sv
// -----------------------------------------------------------------------------
// tb_imem_sync_loadable
//   Directed bench for imem_sync_loadable. The bench keeps its own model of the
//   memory, the IDLE/LOAD state and the load_done flag. Each accepted fetch
//   pushes its expected result onto a scoreboard queue, and the entry is popped
//   and compared on the cycle after acceptance.
// -----------------------------------------------------------------------------
module tb_imem_sync_loadable;
   localparam int DATA_W = 8;
   localparam int ADDR_W = 8;
   localparam int DEPTH  = 32;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              fetch_req = 1'b0;
   logic [ADDR_W-1:0] fetch_addr = '0;
   logic              fetch_ready;
   logic              instr_valid;
   logic [DATA_W-1:0] instruction;
   logic              addr_err;
   logic              load_en = 1'b0;
   logic [ADDR_W-1:0] load_addr = '0;
   logic [DATA_W-1:0] load_data = '0;
   logic              load_done;
   logic              parity_err;

   imem_sync_loadable #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
      .instr_valid(instr_valid), .instruction(instruction), .addr_err(addr_err),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
      .load_done(load_done), .parity_err(parity_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [DATA_W-1:0] instr;
      logic              aerr;
      logic              perr;
   } exp_t;

   exp_t              sb[$];
   logic [DATA_W-1:0] mmem [DEPTH];
   logic              mstate;        // 0 = IDLE, 1 = LOAD
   logic [DATA_W-1:0] m_instr;
   logic              m_done;
   logic              last_acc;
   int                par_inj_addr = -1;
   int                errors = 0;
   int                checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic boot_model();
      for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
      mmem[0] = 8'h49; mmem[1] = 8'hC1; mmem[2] = 8'h18;
      mmem[3] = 8'hA9; mmem[4] = 8'h4D;
   endtask

   // One clock cycle. The caller drives the inputs first. This task checks
   // fetch_ready before the edge, advances the model at the edge, and checks
   // the registered outputs 1 ns after the edge.
   task automatic step();
      logic acc;
      logic exp_ready;
      exp_t e;
      #1;
      exp_ready = !load_en && !mstate;
      if (!reset) chk("fetch_ready", {31'd0, fetch_ready}, {31'd0, exp_ready});
      acc = !reset && fetch_req && exp_ready;
      if (acc) begin
         e.instr = (fetch_addr < DEPTH) ? mmem[fetch_addr] : '0;
         e.aerr  = (fetch_addr >= DEPTH);
         e.perr  = (int'(fetch_addr) == par_inj_addr);
         sb.push_back(e);
      end
      @(posedge clk);
      if (reset) begin
         boot_model();
         mstate  = 1'b0;
         m_instr = '0;
         m_done  = 1'b0;
         sb.delete();
      end else begin
         if (load_en && load_addr < DEPTH) mmem[load_addr] = load_data;
         if (load_en) m_done = 1'b1;
         mstate = load_en;
      end
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         m_instr = e.instr;
         chk("instr_valid", {31'd0, instr_valid}, 32'd1);
         chk("instruction", {24'd0, instruction}, {24'd0, e.instr});
         chk("addr_err", {31'd0, addr_err}, {31'd0, e.aerr});
         chk("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
         $display("fetch addr=%0d instr=%02h addr_err=%0d parity_err=%0d",
                  fetch_addr, instruction, addr_err, parity_err);
      end else begin
         chk("instr_valid_idle", {31'd0, instr_valid}, 32'd0);
         chk("addr_err_idle", {31'd0, addr_err}, 32'd0);
         chk("parity_err_idle", {31'd0, parity_err}, 32'd0);
         chk("instruction_hold", {24'd0, instruction}, {24'd0, m_instr});
      end
      chk("load_done", {31'd0, load_done}, {31'd0, m_done});
      last_acc = acc;
   endtask

   // Holds the request until it is accepted, giving up after 8 cycles.
   task automatic fetch(input logic [ADDR_W-1:0] a);
      fetch_req  = 1'b1;
      fetch_addr = a;
      for (int i = 0; i < 8; i++) begin
         step();
         if (last_acc) break;
      end
      chk("fetch_accepted", {31'd0, last_acc}, 32'd1);
      fetch_req = 1'b0;
   endtask

   task automatic load(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      load_en = 1'b1; load_addr = a; load_data = d;
      step();
      $display("load addr=%0d data=%02h", a, d);
      load_en = 1'b0;
   endtask

   initial begin
      boot_model();
      mstate = 1'b0; m_instr = '0; m_done = 1'b0; last_acc = 1'b0;

      // Reset, then check the post-reset outputs.
      reset = 1'b1; step(); step();
      reset = 1'b0; step();

      // Back-to-back fetch of the boot image, one word per cycle.
      fetch_req = 1'b1;
      for (int a = 0; a < 5; a++) begin
         fetch_addr = ADDR_W'(a);
         step();
         chk("b2b_accept", {31'd0, last_acc}, 32'd1);
      end
      fetch_req = 1'b0; step();

      // Zero words, the last word and an out-of-range address.
      fetch(8'd5); fetch(8'd31); fetch(8'd32); fetch(8'd200); step();

      // Load, then read the new data back.
      load(8'd7, 8'h3C); fetch(8'd7); step();

      // A load and a fetch in the same cycle: the fetch is stalled, not lost.
      load_en = 1'b1; load_addr = 8'd10; load_data = 8'h5A;
      fetch_req = 1'b1; fetch_addr = 8'd10;
      step();
      load_en = 1'b0;
      fetch(8'd10); step();

      // A write out of range is ignored and must not alias onto address 0.
      load(8'd32, 8'h77); fetch(8'd0); fetch(8'd7); step();

      // Load 2, then assert reset together with a pending fetch.
      load(8'd2, 8'hFF); fetch(8'd2);
      fetch_req = 1'b1; fetch_addr = 8'd2; reset = 1'b1;
      step();
      reset = 1'b0; fetch_req = 1'b0; step();
      fetch(8'd2); step();

`ifdef IMEM_PARITY_EN
      // 8'hA9 has even weight, so its stored parity bit is 0. Force it to 1.
      force dut.par_reg[3] = 1'b1;
      par_inj_addr = 3;
      fetch(8'd3);
      release dut.par_reg[3];
      par_inj_addr = -1;
      reset = 1'b1; step(); reset = 1'b0; step();
      fetch(8'd3);
`else
      fetch(8'd3);
`endif
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Absolute time limit, so that a hung run still reports and ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
